// File: rtl/uart_core_if.sv
// Decoder-facing byte channels of the UART: transmit request and receive data.
interface uart_core_if;
  logic [7:0] DataIn;
  logic       DataInValid;
  logic       DataInReady;
  logic [7:0] DataOut;
  logic       DataOutValid;
  logic       DataOutReady;

  modport master (
    output DataIn, DataInValid, DataOutReady,
    input  DataInReady, DataOut, DataOutValid
  );

  modport slave (
    input  DataIn, DataInValid, DataOutReady,
    output DataInReady, DataOut, DataOutValid
  );
endinterface

// File: rtl/uart_core.sv
// 8N1 UART engine: serializes handed-over bytes onto SOut and deserializes
// SIn frames into a single-entry receive register with valid/ready.
module uart_core #(
  parameter int ClockFreq = 100_000_000,
  parameter int BaudRate  = 115_200
) (
  input  logic        Clock,
  input  logic        Reset_n,
  uart_core_if.slave  bus,
  input  logic        SIn,
  output logic        SOut
);
  localparam int SymbolEdgeTime = ClockFreq / BaudRate;
  localparam int HalfSymbol     = SymbolEdgeTime / 2;
  localparam int CW             = (SymbolEdgeTime > 1) ? $clog2(SymbolEdgeTime) : 1;
  localparam logic [CW-1:0] CYC_LAST  = CW'(SymbolEdgeTime - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HalfSymbol - 1);

  // ---------------- transmitter ----------------
  typedef enum logic {TX_IDLE, TX_SEND} tx_e;

  tx_e           tx_state_q, tx_state_d;
  logic [9:0]    tx_frame_q, tx_frame_d;
  logic [3:0]    tx_bit_q,   tx_bit_d;
  logic [CW-1:0] tx_cyc_q,   tx_cyc_d;
  logic          sout_q,     sout_d;

  assign bus.DataInReady = (tx_state_q == TX_IDLE);
  assign SOut            = sout_q;

  // TX next state; SOut is registered from the next-state frame/bit so the
  // start bit appears on the same edge that leaves idle.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_frame_d = tx_frame_q;
    tx_bit_d   = tx_bit_q;
    tx_cyc_d   = tx_cyc_q;
    sout_d     = 1'b1;
    case (tx_state_q)
      TX_IDLE: begin
        if (bus.DataInValid) begin
          tx_frame_d = {1'b1, bus.DataIn, 1'b0};
          tx_bit_d   = 4'd0;
          tx_cyc_d   = '0;
          tx_state_d = TX_SEND;
        end
      end
      TX_SEND: begin
        if (tx_cyc_q == CYC_LAST) begin
          tx_cyc_d = '0;
          if (tx_bit_q == 4'd9) tx_state_d = TX_IDLE;
          else                  tx_bit_d   = tx_bit_q + 4'd1;
        end else begin
          tx_cyc_d = tx_cyc_q + CW'(1);
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    if (tx_state_d == TX_SEND) sout_d = tx_frame_d[tx_bit_d];
  end

  // TX state register
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      tx_state_q <= TX_IDLE;
      tx_frame_q <= '0;
      tx_bit_q   <= '0;
      tx_cyc_q   <= '0;
      sout_q     <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_frame_q <= tx_frame_d;
      tx_bit_q   <= tx_bit_d;
      tx_cyc_q   <= tx_cyc_d;
      sout_q     <= sout_d;
    end
  end

  // ---------------- receiver ----------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_e;

  logic [1:0]    sync_q;
  logic          sin_s;
  rx_e           rx_state_q, rx_state_d;
  logic [3:0]    rx_bit_q,   rx_bit_d;
  logic [CW-1:0] rx_cyc_q,   rx_cyc_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic [7:0]    dout_q,     dout_d;
  logic          dval_q,     dval_d;

  assign sin_s            = sync_q[1];
  assign bus.DataOut      = dout_q;
  assign bus.DataOutValid = dval_q;

  // Two-flop synchronizer; idles high so reset never looks like a start bit
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) sync_q <= 2'b11;
    else          sync_q <= {sync_q[0], SIn};
  end

  // RX next state; a consume in the stop-sample cycle frees the register
  // before the new byte is considered, so it loads instead of overrunning.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_bit_d   = rx_bit_q;
    rx_cyc_d   = rx_cyc_q;
    rx_shift_d = rx_shift_q;
    dout_d     = dout_q;
    dval_d     = dval_q;
    if (bus.DataOutReady) dval_d = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cyc_d = '0;
        if (!sin_s) rx_state_d = RX_START;
      end
      RX_START: begin
        if (rx_cyc_q == HALF_LAST) begin
          rx_cyc_d   = '0;
          rx_bit_d   = 4'd0;
          rx_state_d = sin_s ? RX_IDLE : RX_DATA;
        end else begin
          rx_cyc_d = rx_cyc_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (rx_cyc_q == CYC_LAST) begin
          rx_cyc_d   = '0;
          rx_shift_d = {sin_s, rx_shift_q[7:1]};
          if (rx_bit_q == 4'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 4'd1;
        end else begin
          rx_cyc_d = rx_cyc_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (rx_cyc_q == CYC_LAST) begin
          rx_cyc_d   = '0;
          rx_state_d = RX_IDLE;
          if (sin_s && !dval_d) begin
            dout_d = rx_shift_q;
            dval_d = 1'b1;
          end
        end else begin
          rx_cyc_d = rx_cyc_q + CW'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // RX state register
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      rx_state_q <= RX_IDLE;
      rx_bit_q   <= '0;
      rx_cyc_q   <= '0;
      rx_shift_q <= '0;
      dout_q     <= '0;
      dval_q     <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_bit_q   <= rx_bit_d;
      rx_cyc_q   <= rx_cyc_d;
      rx_shift_q <= rx_shift_d;
      dout_q     <= dout_d;
      dval_q     <= dval_d;
    end
  end
endmodule

// File: doc/uart_core.md
# uart_core

Serial UART engine on the memory-mapped I/O side of the MIPS datapath. It converts bytes handed over by the UART address decoder into 8N1 serial frames on `SOut`, and deserializes frames from `SIn` into bytes the decoder reads back. The decoder-facing side is a pair of valid/ready byte channels. `DataInReady`, `DataOutValid` and `DataOut` are the status and data the CPU polls at 0x80000000, 0x80000004 and 0x8000000c.

## Interface
- `ClockFreq`, 100_000_000: system clock frequency, in Hz.
- `BaudRate`, 115_200: serial bit rate.
- `SymbolEdgeTime`, localparam = `ClockFreq/BaudRate` (integer division, truncating): cycles per bit.
- `Clock` input 1: system clock; everything is on the rising edge.
- `Reset_n` input 1: asynchronous, active-low reset.
- `DataIn` input 8: byte to transmit (decoder `Write`).
- `DataInValid` input 1: transmit request (decoder `DataInValid`, already gated by stall).
- `DataInReady` output 1: transmitter idle; can accept a byte.
- `DataOut` output 8: last received byte.
- `DataOutValid` output 1: `DataOut` holds an unconsumed byte.
- `DataOutReady` input 1: consumer takes `DataOut` (decoder `DataOutReady`, single-cycle pulse).
- `SIn` input 1: serial receive line, asynchronous to `Clock`.
- `SOut` output 1: serial transmit line.

## Operation
- Frame format, both directions: start bit 0, 8 data bits LSB first, stop bit 1. No parity.

**Transmitter**
- Two states: `TX_IDLE` and `TX_SEND`.
- A handshake occurs when `DataInValid && DataInReady`.
- On handshake:
  - latch the 10-bit frame `{1'b1, DataIn, 1'b0}`;
  - clear the bit counter and cycle counter;
  - go to `TX_SEND`.
- In `TX_SEND`, `SOut` = frame[bit].
- The cycle counter runs 0..`SymbolEdgeTime`-1. At terminal count it wraps and bit increments.
- After bit 9 (the stop bit) completes, return to `TX_IDLE`.
- `DataInReady` = (state == `TX_IDLE`).
- `DataInValid` while not ready is ignored. It is not queued.
- `SOut` = 1 in `TX_IDLE`.

**Receiver**
- `SIn` passes through a 2-flop synchronizer. All receive logic uses the synchronized value `sin_s`.
- Four states: `RX_IDLE`, `RX_START`, `RX_DATA`, `RX_STOP`.
- `RX_IDLE` → `RX_START` on `sin_s` == 0.
- In `RX_START`, wait `SymbolEdgeTime/2` cycles, then sample the start bit at mid-bit:
  - if the sample is 1, it is a false start: return to `RX_IDLE`;
  - if the sample is 0, go to `RX_DATA` with the counter cleared.
- In `RX_DATA`, sample every `SymbolEdgeTime` cycles, 8 times. Shift each sample in at the MSB, giving LSB-first assembly.
- In `RX_STOP`, sample once more after `SymbolEdgeTime` cycles:
  - stop sample = 1 and `DataOutValid` == 0: load `DataOut` and set `DataOutValid`;
  - stop sample = 1 and `DataOutValid` == 1 (overrun): discard the new byte. The old byte and the valid flag are retained;
  - stop sample = 0 (framing error): discard the byte.
  - In every case, return to `RX_IDLE` on the cycle of the stop sample.
- On the same-cycle `DataOutReady` pulse in the stop-sample cycle, the consume is applied first. The new byte therefore loads and `DataOutValid` stays 1.
- Otherwise, `DataOutReady` while `DataOutValid` clears `DataOutValid` on the next edge. `DataOut` is left unchanged.
- `DataOutReady` while `!DataOutValid` has no effect.

**Reset**
- Reset is asynchronous. On assertion, mid-frame transfers are abandoned and no partial byte is ever presented.
- Reset values:
  - `SOut` = 1, `DataInReady` = 1, `DataOutValid` = 0, `DataOut` = 8'h00;
  - both FSMs idle, all counters 0, synchronizer flops 1.

**Widths**
- Cycle counters are `$clog2(SymbolEdgeTime)` bits.
- Bit counters are 4 bits.

## Timing
- TX latency:
  - handshake on edge N; `DataInReady` is low and `SOut` goes to 0 from edge N+1;
  - each bit lasts exactly `SymbolEdgeTime` cycles;
  - `DataInReady` returns high 10×`SymbolEdgeTime` cycles after edge N+1 (stop bit fully sent);
  - back-to-back frames need no idle bit between them.
- With the defaults, `SymbolEdgeTime` = 868 and one frame is 8680 cycles.
- RX latency:
  - the first `sin_s` low is seen 2 cycles after the `SIn` fall;
  - the start sample comes `SymbolEdgeTime/2` cycles later;
  - `DataOutValid` rises on the edge after the stop-bit mid-sample, about 9.5 bit times after the start edge plus 3 cycles.
- All outputs are registered except `DataInReady`, which is decoded from a state register.

## Test plan
Use `ClockFreq`=1000 and `BaudRate`=100, so `SymbolEdgeTime`=10.
1. Drive `DataIn`=8'hA5 with a 1-cycle `DataInValid` in idle. Required: `SOut` sequence 0,1,0,1,0,0,1,0,1,1, each bit held 10 cycles; `DataInReady` low for exactly 100 cycles.
2. Drive `SIn` with a 0x3C frame at 10 cycles per bit. Required: `DataOutValid`=1 with `DataOut`=8'h3C. Then pulse `DataOutReady`: `DataOutValid`=0 next cycle and `DataOut` stays 8'h3C.
3. Send 0x11, then 0x22, without consuming. Required: `DataOut` stays 8'h11 and `DataOutValid` stays 1 (overrun drop).
4. Send a frame with stop bit 0, and separately a 3-cycle low glitch on `SIn`. Required: `DataOutValid` stays 0 in both cases and the receiver accepts the next valid frame correctly.
5. Loop `SOut` back to `SIn` and send 0x00, 0xFF, 0x5A back to back. Required: each byte is received intact.
6. Pull `Reset_n` low mid-TX (bit 4) and mid-RX. Required: `SOut`=1, `DataInReady`=1 and `DataOutValid`=0 immediately, with no spurious byte after release.
